serial_add_ctrl: RTL and testbench
==================================

SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits; legal range 2..32.
REQ-002 Clk  input  1  single clock; all state updates on rising edge.
REQ-003 Rst_n  input  1  synchronous, active-low reset, sampled on rising Clk.
REQ-004 Start  input  1  request to begin an addition; sampled only in IDLE.
REQ-005 A  input  WIDTH  first operand; captured when Start is accepted.
REQ-006 B  input  WIDTH  second operand; captured when Start is accepted.
REQ-007 Cin  input  1  carry-in; captured when Start is accepted.
REQ-008 Busy  output  1  high while bits are being processed (RUN).
REQ-009 Done  output  1  one-cycle pulse; result valid.
REQ-010 Sum  output  WIDTH  result; holds last completed value.
REQ-011 Cout  output  1  final carry-out; holds last completed value.

Function
REQ-012 Block SHALL compute {Cout,Sum} = A + B + Cin using one 1-bit full-adder cell, one bit per cycle, LSB first.
REQ-013 FSM states SHALL be IDLE, RUN, DONE.
REQ-014 IDLE -> RUN when Start=1; A, B, Cin latched into internal shift registers/carry flop; bit counter cleared.
REQ-015 IDLE with Start=0 SHALL remain IDLE.
REQ-016 In RUN each cycle: full-adder inputs = operand LSBs and carry flop; sum bit shifted into result register MSB side; carry flop updated; operands shift right; counter increments.
REQ-017 RUN -> DONE after exactly WIDTH RUN cycles (counter reaches WIDTH-1).
REQ-018 DONE -> IDLE unconditionally after one cycle.
REQ-019 Latency: Start accepted at edge 0 -> Busy=1 in cycles 1..WIDTH, Done=1 in cycle WIDTH+1, IDLE in cycle WIDTH+2.
REQ-020 Busy SHALL equal (state==RUN); Done SHALL equal (state==DONE); both registered-state decodes, no combinational path from inputs.
REQ-021 Sum and Cout SHALL update only at the RUN->DONE edge and hold until the next such edge; partial results never visible on Sum/Cout.
REQ-022 Start in RUN or DONE SHALL be ignored (not queued); A/B/Cin changes during RUN SHALL not affect the result.
REQ-023 Back-to-back: Start held high SHALL be re-accepted in the first IDLE cycle after DONE, giving one operation per WIDTH+2 cycles.
REQ-024 Overflow SHALL appear only on Cout; Sum wraps modulo 2^WIDTH.

Reset
REQ-025 Rst_n=0 at a rising edge SHALL force state IDLE, Busy=0, Done=0, Sum=0, Cout=0, counter=0, carry flop=0.
REQ-026 Reset asserted during RUN or DONE SHALL abort the operation; no Done pulse follows and Sum/Cout read 0.
REQ-027 Start sampled in the same cycle as Rst_n=0 SHALL be ignored; reset has priority.

Structure
REQ-028 Shared package serial_add_pkg SHALL hold the state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2), the WIDTH default, and the counter-width function clog2(WIDTH).
REQ-029 One sub-module fa_cell (combinational 1-bit full adder: a, b, ci -> s, co) SHALL be instantiated once; all sequencing lives in serial_add_ctrl.
REQ-030 Unused state encoding 2'd3 SHALL recover to IDLE on the next edge.

Verification (WIDTH=8)
REQ-031 Reset 2 cycles, then A=0x00,B=0x00,Cin=0, Start 1 cycle -> Busy high 8 cycles, Done in cycle 9, Sum=0x00, Cout=0.
REQ-032 A=0xFF,B=0x01,Cin=0 -> Sum=0x00, Cout=1; A=0xA5,B=0x5A,Cin=1 -> Sum=0x00, Cout=1; A=0x3C,B=0x42,Cin=0 -> Sum=0x7E, Cout=0.
REQ-033 Start pulsed in RUN cycle 3 with different A/B -> ignored; result matches first operands; exactly one Done.
REQ-034 Start held high continuously for 3 operations -> Done pulses spaced exactly 10 cycles apart, each with correct result.
REQ-035 Rst_n low in RUN cycle 5 -> next cycle IDLE, Busy=0, no Done, Sum=0x00, Cout=0; new Start afterwards completes normally.
REQ-036 Exhaustive 1-bit-cell check: all 8 (a,b,ci) combinations via fa_cell-level bench, plus random 1000 operand sets compared to A+B+Cin reference model.

Source files
------------

// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder: state encoding, default
// operand width and the counter-width helper.
package serial_add_pkg;

  localparam int WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bits needed to count 0..n-1; returns 0 for n <= 1.
  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/serial_add_ctrl_fa_cell.sv
// Combinational 1-bit full adder, the only arithmetic in the serial adder.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  // Sum and carry of three input bits.
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: {Cout,Sum} = A + B + Cin, one bit per cycle, LSB first,
// through a single full-adder cell.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for Start; operands and carry-in captured on accept
//   RUN   | one bit per cycle through the full adder, WIDTH cycles
//   DONE  | one-cycle Done pulse; Sum/Cout already hold the new result
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout
);

  // Counter needs at least one bit even for the smallest legal width.
  localparam int CW = (clog2(WIDTH) < 1) ? 1 : clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t state_q;
  state_t state_d;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  // Holds the WIDTH-1 sum bits produced so far; the last bit comes straight
  // from the cell on the final RUN cycle.
  logic [WIDTH-2:0] res_sr;
  logic [WIDTH-1:0] res_next;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;
  logic             fa_s;
  logic             fa_co;
  logic             last_bit;

  fa_cell u_fa (
    .a  (a_sr[0]),
    .b  (b_sr[0]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  assign last_bit = (cnt_q == CNT_LAST);
  assign res_next = {fa_s, res_sr};

  // State register; reset has priority over everything including Start.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; the unused encoding falls back to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (Start) state_d = RUN;
      RUN:     if (last_bit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Status outputs decode the registered state only.
  assign Busy = (state_q == RUN);
  assign Done = (state_q == DONE);

  // Operand capture, serial datapath and result registers.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      a_sr    <= '0;
      b_sr    <= '0;
      res_sr  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      Sum     <= '0;
      Cout    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (Start) begin
            a_sr    <= A;
            b_sr    <= B;
            carry_q <= Cin;
            cnt_q   <= '0;
          end
        end
        RUN: begin
          a_sr    <= a_sr >> 1;
          b_sr    <= b_sr >> 1;
          res_sr  <= res_next[WIDTH-1:1];
          carry_q <= fa_co;
          cnt_q   <= cnt_q + 1'b1;
          // Outputs move only on the RUN->DONE edge so partial sums stay hidden.
          if (last_bit) begin
            Sum  <= res_next;
            Cout <= fa_co;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl at WIDTH=8.
module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         Clk = 1'b0;
  logic         Rst_n;
  logic         Start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         Cin;
  logic         Busy;
  logic         Done;
  logic [W-1:0] Sum;
  logic         Cout;

  logic fa_a, fa_b, fa_ci, fa_s, fa_co;

  int n_tests = 0;
  int n_fail  = 0;

  // Model of what Sum/Cout should currently hold.
  logic [W-1:0] m_sum;
  logic         m_cout;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
    logic [W-1:0] s;
    logic         co;
  } vec_t;

  vec_t vt[6];

  always #5 Clk = ~Clk;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .Start (Start),
    .A     (A),
    .B     (B),
    .Cin   (Cin),
    .Busy  (Busy),
    .Done  (Done),
    .Sum   (Sum),
    .Cout  (Cout)
  );

  fa_cell u_fa_chk (
    .a  (fa_a),
    .b  (fa_b),
    .ci (fa_ci),
    .s  (fa_s),
    .co (fa_co)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // One full operation with cycle-exact checks of Busy/Done/Sum/Cout.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
    logic [W:0] r;
    r = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
    A = a; B = b; Cin = ci; Start = 1'b1;
    step();
    Start = 1'b0;
    A = ~a; B = ~b; Cin = ~ci;
    for (int c = 1; c <= W; c++) begin
      chk("busy_run", Busy, 1);
      chk("done_run", Done, 0);
      chk("sum_hold", Sum, m_sum);
      chk("cout_hold", Cout, m_cout);
      if (c < W) step();
    end
    step();
    chk("done_pulse", Done, 1);
    chk("busy_done", Busy, 0);
    chk("sum", Sum, r[W-1:0]);
    chk("cout", Cout, r[W]);
    m_sum  = r[W-1:0];
    m_cout = r[W];
    step();
    chk("done_clear", Done, 0);
    chk("busy_idle", Busy, 0);
  endtask

  initial begin
    logic [W-1:0] ops_a[3];
    logic [W-1:0] ops_b[3];
    logic [W:0]   er;
    int dcyc[3];
    int ndone;
    int nbad;

    vt[0] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vt[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vt[2] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1};
    vt[3] = '{8'h3C, 8'h42, 1'b0, 8'h7E, 1'b0};
    vt[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    vt[5] = '{8'h7F, 8'h00, 1'b1, 8'h80, 1'b0};

    // Full-adder cell truth table.
    fa_a = 0; fa_b = 0; fa_ci = 0;
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      fa_a = v[0]; fa_b = v[1]; fa_ci = v[2];
      #1;
      chk("fa_cell", {30'd0, fa_co, fa_s}, 32'(v[0]) + 32'(v[1]) + 32'(v[2]));
    end

    // Reset state.
    Rst_n = 1'b0; Start = 1'b0; A = '0; B = '0; Cin = 1'b0;
    step();
    step();
    chk("rst_busy", Busy, 0);
    chk("rst_done", Done, 0);
    chk("rst_sum", Sum, 0);
    chk("rst_cout", Cout, 0);
    Rst_n = 1'b1;
    m_sum = '0; m_cout = 1'b0;
    step();
    chk("idle_stays", Busy, 0);

    // Directed vectors.
    for (int i = 0; i < 6; i++) begin
      run_op(vt[i].a, vt[i].b, vt[i].ci);
      chk("tbl_sum", Sum, vt[i].s);
      chk("tbl_cout", Cout, vt[i].co);
    end

    // Start pulsed during RUN cycle 3 is ignored.
    A = 8'h12; B = 8'h34; Cin = 1'b0; Start = 1'b1;
    step();
    Start = 1'b0;
    ndone = 0;
    for (int c = 1; c <= 14; c++) begin
      if (Done) begin
        ndone++;
        chk("ign_sum", Sum, 8'h46);
        chk("ign_cout", Cout, 0);
      end
      if (c == 3) begin
        Start = 1'b1; A = 8'hF0; B = 8'hF0; Cin = 1'b1;
      end else begin
        Start = 1'b0;
      end
      step();
    end
    chk("ign_one_done", ndone, 1);
    chk("ign_idle", Busy, 0);
    m_sum = 8'h46; m_cout = 1'b0;

    // Back-to-back with Start held high.
    ops_a[0] = 8'h10; ops_b[0] = 8'h20;
    ops_a[1] = 8'hF0; ops_b[1] = 8'h20;
    ops_a[2] = 8'h55; ops_b[2] = 8'h55;
    dcyc[0] = 0; dcyc[1] = 0; dcyc[2] = 0;
    ndone = 0;
    A = ops_a[0]; B = ops_b[0]; Cin = 1'b0; Start = 1'b1;
    step();
    for (int c = 1; c <= 40; c++) begin
      if (Done) begin
        if (ndone < 3) begin
          er = {1'b0, ops_a[ndone]} + {1'b0, ops_b[ndone]};
          chk("b2b_sum", Sum, er[W-1:0]);
          chk("b2b_cout", Cout, er[W]);
          m_sum = er[W-1:0]; m_cout = er[W];
          dcyc[ndone] = c;
        end
        ndone++;
        if (ndone < 3) begin
          A = ops_a[ndone]; B = ops_b[ndone];
        end else begin
          Start = 1'b0;
        end
      end
      step();
    end
    Start = 1'b0;
    chk("b2b_count", ndone, 3);
    chk("b2b_first", dcyc[0], 9);
    chk("b2b_gap1", dcyc[1] - dcyc[0], 10);
    chk("b2b_gap2", dcyc[2] - dcyc[1], 10);

    // Reset in RUN cycle 5 aborts; Start during reset is ignored.
    run_op(8'h3C, 8'h42, 1'b0);
    A = 8'h11; B = 8'h22; Cin = 1'b0; Start = 1'b1;
    step();
    Start = 1'b0;
    for (int c = 2; c <= 5; c++) step();
    Rst_n = 1'b0; Start = 1'b1;
    step();
    chk("abort_busy", Busy, 0);
    chk("abort_done", Done, 0);
    chk("abort_sum", Sum, 0);
    chk("abort_cout", Cout, 0);
    Rst_n = 1'b1; Start = 1'b0;
    m_sum = '0; m_cout = 1'b0;
    nbad = 0;
    for (int c = 0; c < 12; c++) begin
      if (Done || Busy) nbad++;
      step();
    end
    chk("abort_quiet", nbad, 0);
    chk("abort_sum_hold", Sum, 0);
    run_op(8'h0F, 8'h01, 1'b1);

    // Random operands against plain-arithmetic reference.
    for (int i = 0; i < 1000; i++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      logic         rc;
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
      run_op(ra, rb, rc);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
